mips_reg_file: RTL and testbench
================================

Name: mips_reg_file

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle R-type MIPS datapath.
- Two combinational read ports supply the rs/rt operands to the ALU (and, or, nor, add, sub, slt units).
- One synchronous write port accepts the ALU result at write-back for rd.
- Includes $zero hardwiring, same-cycle write-to-read bypass, a debug read port, and a write counter for verification.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- BYPASS_EN, 1, 1 = a read of the register being written this cycle returns the write data; 0 = returns the old value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- read_addr_a  input  ADDR_W  rs index.
- read_addr_b  input  ADDR_W  rt index.
- read_data_a  output  DATA_W  rs operand to ALU input_a.
- read_data_b  output  DATA_W  rt operand to ALU input_b.
- write_en  input  1  RegWrite from control.
- write_addr  input  ADDR_W  rd index.
- write_data  input  DATA_W  ALU result to be written.
- dbg_addr  input  ADDR_W  debug/testbench read index.
- dbg_data  output  DATA_W  contents of dbg_addr (never bypassed).
- write_count  output  16  number of committed writes since reset.

Behaviour:
- Reset:
  - rst_n low clears all 32 registers to 0 immediately; no clock edge is needed.
  - write_count is cleared to 0.
  - While rst_n is low, read_data_a, read_data_b and dbg_data all read 0.
- Reset deassertion is sampled on clk; the first write can commit on the first rising edge with rst_n high.
- Write:
  - On a rising edge with write_en=1 and write_addr!=0, reg[write_addr] <= write_data and write_count increments by 1.
  - write_count wraps 0xFFFF -> 0x0000.
- Register 0:
  - Writes with write_addr=0 are discarded and write_count does not increment.
  - Any read of index 0 returns 0 on every port, regardless of bypass.
- Read:
  - Read ports are purely combinational with zero-cycle latency; the data reflects the current array contents.
  - If BYPASS_EN=1, write_en=1, write_addr!=0 and read_addr_x==write_addr, then read_data_x = write_data in that same cycle.
  - A simultaneous read on both ports of the same index returns identical data on both.
- Write with write_en=0: no state change, regardless of write_addr/write_data.
- Reset mid-operation:
  - Asserting rst_n while write_en=1 aborts the write; the register holds 0 after reset.
  - write_count does not count the aborted write.
- X handling: X on a read address yields X on that port only. Array state and the other ports are unaffected.
- No handshake or stall; the block accepts one write per cycle and is always ready.

Test Plan:
- Reset: pulse rst_n low mid-cycle after writing reg[5]=0x12345678 -> dbg_data(5)=0 and write_count=0 immediately, with no clock edge.
- Write/read: write reg[8]=0xFFFF0000 and reg[9]=0x0F0F0F0F. Next cycle read a=8, b=9 -> read_data_a=0xFFFF0000 and read_data_b=0x0F0F0F0F; a downstream nor of the two yields 0x0000F0F0. write_count=2.
- $zero: write_en=1, write_addr=0, write_data=0xDEADBEEF -> read_data_a(0)=0 and write_count unchanged.
- Bypass: with reg[3]=0x11111111, write reg[3]=0xAAAAAAAA while read_addr_a=3 in the same cycle.
  - BYPASS_EN=1: read_data_a=0xAAAAAAAA before the edge.
  - BYPASS_EN=0: read_data_a=0x11111111 before the edge and 0xAAAAAAAA after it.
- Sweep/wrap: write reg[i]=i*0x01010101 for i=1..31 and check all indices via dbg_addr. Preload write_count to 0xFFFF via 65535 writes, then one more write -> write_count=0x0000.
- write_en=0 with write_addr=7 and write_data=0xCAFEBABE -> reg[7] unchanged and write_count unchanged.

Source files
------------

// File: rtl/mips_reg_file.sv
// 32-entry register file with two operand read ports, one write port, a debug port and a write counter.
// Reads are combinational (zero cycles); a write commits on the rising edge.
// No backpressure: one write is accepted every cycle.
module mips_reg_file #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_addr_a,
    input  logic [ADDR_W-1:0] read_addr_b,
    output logic [DATA_W-1:0] read_data_a,
    output logic [DATA_W-1:0] read_data_b,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       write_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [15:0]       write_count_q;
    logic [15:0]       write_count_d;
    logic              commit;
    logic              bypass_a;
    logic              bypass_b;

    // Writes to $zero never land, so entry 0 stays at its reset value of 0.
    assign commit = write_en && (write_addr != '0);

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (commit) begin
            regs_d[write_addr] = write_data;
            write_count_d      = write_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    assign bypass_a = (BYPASS_EN != 0) && commit && (read_addr_a == write_addr);
    assign bypass_b = (BYPASS_EN != 0) && commit && (read_addr_b == write_addr);

    // Reset gating keeps a pending bypass from leaking write_data while rst_n is low.
    assign read_data_a = (!rst_n || read_addr_a == '0) ? '0 :
                         bypass_a ? write_data : regs_q[read_addr_a];
    assign read_data_b = (!rst_n || read_addr_b == '0) ? '0 :
                         bypass_b ? write_data : regs_q[read_addr_b];
    assign dbg_data    = (!rst_n || dbg_addr == '0) ? '0 : regs_q[dbg_addr];
    assign write_count = write_count_q;

endmodule

// File: tb/tb_mips_reg_file.sv
// Bench for mips_reg_file: one bypassing and one non-bypassing instance share stimulus and are checked against an array model.
module tb_mips_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra, rb, wa, da;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rda1, rdb1, dbg1, rda0, rdb0, dbg0;
    logic [15:0] wc1, wc0;

    logic [31:0] mem [32];
    logic [15:0] cnt;
    int          tests  = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_addr_a(ra), .read_addr_b(rb),
        .read_data_a(rda1), .read_data_b(rdb1),
        .write_en(we), .write_addr(wa), .write_data(wd),
        .dbg_addr(da), .dbg_data(dbg1), .write_count(wc1)
    );

    mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .read_addr_a(ra), .read_addr_b(rb),
        .read_data_a(rda0), .read_data_b(rdb0),
        .write_en(we), .write_addr(wa), .write_data(wd),
        .dbg_addr(da), .dbg_data(dbg0), .write_count(wc0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        cnt = 16'h0;
    endtask

    // Value a read port should present right now, from the architectural rules.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (byp && we && wa != 5'd0 && wa == a) return wd;
        return mem[a];
    endfunction

    // Drive one cycle of inputs (called with clk low), optionally check, then commit.
    task automatic cyc(input logic w, input logic [4:0] wad, input logic [31:0] wdat,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input bit check);
        we = w; wa = wad; wd = wdat; ra = a; rb = b; da = d;
        #1;
        if (check) begin
            chk("rd_a_byp",   rda1, exp_rd(a, 1'b1));
            chk("rd_b_byp",   rdb1, exp_rd(b, 1'b1));
            chk("rd_a_nobyp", rda0, exp_rd(a, 1'b0));
            chk("rd_b_nobyp", rdb0, exp_rd(b, 1'b0));
            chk("dbg_byp",    dbg1, (d == 5'd0) ? 32'h0 : mem[d]);
            chk("dbg_nobyp",  dbg0, (d == 5'd0) ? 32'h0 : mem[d]);
            chk("count",      {16'h0, wc1}, {16'h0, cnt});
            chk("count_nb",   {16'h0, wc0}, {16'h0, cnt});
        end
        @(posedge clk);
        if (rst_n && w && wad != 5'd0) begin
            mem[wad] = wdat;
            cnt      = cnt + 16'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] a, b, w;
        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = 5'd8; rb = 5'd9; da = 5'd5;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rd_a",  rda1, 32'h0);
        chk("reset_dbg",   dbg1, 32'h0);
        chk("reset_count", {16'h0, wc1}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset pulse with no clock edge.
        cyc(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5, 5'd5, 1'b1);
        we = 1'b0; #1;
        chk("pre_reset_dbg5", dbg1, 32'h12345678);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_dbg5",  dbg1, 32'h0);
        chk("async_reset_count", {16'h0, wc1}, 32'h0);
        // A write attempted during reset must be dropped, and bypass must not leak.
        we = 1'b1; wa = 5'd5; wd = 32'h0BAD0BAD; ra = 5'd5; #1;
        chk("reset_bypass_blocked", rda1, 32'h0);
        @(negedge clk);
        we = 1'b0; rst_n = 1'b1; #1;
        chk("aborted_write_dbg5",  dbg1, 32'h0);
        chk("aborted_write_count", {16'h0, wc1}, 32'h0);
        @(negedge clk);

        // Write/read and downstream nor.
        cyc(1'b1, 5'd8, 32'hFFFF0000, 5'd0, 5'd0, 5'd8, 1'b1);
        cyc(1'b1, 5'd9, 32'h0F0F0F0F, 5'd8, 5'd9, 5'd9, 1'b1);
        cyc(1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 5'd8, 1'b1);
        #1;
        chk("rd_a_reg8",  rda1, 32'hFFFF0000);
        chk("rd_b_reg9",  rdb1, 32'h0F0F0F0F);
        chk("nor_result", ~(rda1 | rdb1), 32'h0000F0F0);
        chk("count_two",  {16'h0, wc1}, 32'd2);

        // Writes to $zero are discarded.
        cyc(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        chk("zero_rd_a",  rda1, 32'h0);
        chk("zero_count", {16'h0, wc1}, 32'd2);

        // Bypass versus no bypass.
        cyc(1'b1, 5'd3, 32'h11111111, 5'd3, 5'd3, 5'd3, 1'b1);
        we = 1'b1; wa = 5'd3; wd = 32'hAAAAAAAA; ra = 5'd3; rb = 5'd3;
        #1;
        chk("bypass_on",        rda1, 32'hAAAAAAAA);
        chk("bypass_off_pre",   rda0, 32'h11111111);
        chk("bypass_both_same", rdb1, rda1);
        @(posedge clk);
        mem[3] = 32'hAAAAAAAA; cnt = cnt + 16'd1;
        #1 we = 1'b0;
        #1;
        chk("bypass_off_post", rda0, 32'hAAAAAAAA);
        @(negedge clk);

        // write_en=0 leaves state alone.
        cyc(1'b0, 5'd7, 32'hCAFEBABE, 5'd7, 5'd7, 5'd7, 1'b1);
        #1;
        chk("we0_reg7",  dbg1, 32'h0);
        chk("we0_count", {16'h0, wc1}, 32'd4);

        // Sweep every register.
        for (int i = 1; i < 32; i++)
            cyc(1'b1, i[4:0], i * 32'h01010101, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1);
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            da = i[4:0];
            #1;
            chk("sweep_dbg", dbg1, i * 32'h01010101);
        end
        @(negedge clk);

        // Randomized traffic with frequent read/write address collisions.
        for (int n = 0; n < 300; n++) begin
            w = 5'($urandom);
            a = ($urandom_range(0, 2) == 0) ? w : 5'($urandom);
            b = ($urandom_range(0, 2) == 0) ? w : 5'($urandom);
            cyc(1'($urandom), w, $urandom, a, b, 5'($urandom), 1'b1);
        end

        // Drive the counter to 0xFFFF, then wrap it.
        for (int n = 0; n < 70000 && cnt != 16'hFFFF; n++)
            cyc(1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("count_ffff", {16'h0, wc1}, 32'h0000FFFF);
        cyc(1'b1, 5'd12, 32'h5A5A5A5A, 5'd12, 5'd1, 5'd12, 1'b1);
        #1;
        chk("count_wrap",    {16'h0, wc1}, 32'h0);
        chk("count_wrap_nb", {16'h0, wc0}, 32'h0);
        chk("wrap_dbg12",    dbg1, 32'h5A5A5A5A);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
